// File: rtl/arb_rr_pry.sv
// Round-robin arbiter with packet locking and a registered output stage.
// Optional per-requester beat counters are enabled with ARB_RR_PRY_CNT_EN.

module mux_pry #(
  parameter type DAT_T          = logic [7:0],
  parameter int  WIDTH          = 5,
  parameter int  SPLIT          = 2,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] sel,
  input  DAT_T             dat [WIDTH-1:0],
  output logic             vld,
  output DAT_T             out
);

  function automatic int calc_lvl(input int w, input int s);
    int n;
    int l;
    n = 1;
    l = 0;
    while (n < w) begin
      n = n * s;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LVL    = calc_lvl(WIDTH, SPLIT);
  localparam int LEAVES = SPLIT ** LVL;

  generate
    if (IMPLEMENTATION == 0) begin : g_tree
      // Leaves beyond WIDTH are padded with sel=0 so their data never wins.
      logic [LEAVES-1:0] tv [LVL+1];
      DAT_T              td [LVL+1][LEAVES];

      always_comb begin
        int n;
        for (int l = 0; l <= LVL; l++) begin
          tv[l] = '0;
          for (int j = 0; j < LEAVES; j++) td[l][j] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
          tv[0][i] = sel[i];
          td[0][i] = dat[i];
        end
        n = LEAVES;
        for (int l = 0; l < LVL; l++) begin
          n = n / SPLIT;
          for (int j = 0; j < n; j++) begin
            for (int k = SPLIT - 1; k >= 0; k--) begin
              if (tv[l][j*SPLIT+k]) begin
                tv[l+1][j] = 1'b1;
                td[l+1][j] = td[l][j*SPLIT+k];
              end
            end
          end
        end
      end

      assign vld = tv[LVL][0];
      assign out = td[LVL][0];
    end else begin : g_flat
      always_comb begin
        vld = 1'b0;
        out = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (sel[i]) begin
            vld = 1'b1;
            out = dat[i];
          end
        end
      end
    end
  endgenerate

endmodule

module arb_rr_pry #(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 5,
  parameter int  SPLIT          = 2,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req_vld,
  input  logic [WIDTH-1:0]         req_lst,
  input  DAT_T                     req_dat [WIDTH-1:0],
  output logic [WIDTH-1:0]         req_rdy,
  output logic                     out_vld,
  output logic                     out_lst,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output DAT_T                     out_dat,
  input  logic                     out_rdy
`ifdef ARB_RR_PRY_CNT_EN
  ,
  output logic [16-1:0]            cnt [WIDTH-1:0]
`endif
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    lock_idx;
  logic [IW-1:0]    g_idle;
  logic [IW-1:0]    g;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] pry;
  logic [WIDTH-1:0] lock_oh;
  logic [WIDTH-1:0] sel;
  logic             g_vld;
  logic             ld;
  logic             xfer;
  DAT_T             g_dat;

  always_comb begin
    mask    = '0;
    lock_oh = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i]    = (IW'(i) >= ptr);
      lock_oh[i] = (IW'(i) == lock_idx);
    end
  end

  assign pry = |(req_vld & mask) ? (req_vld & mask) : req_vld;

  always_comb begin
    g_idle = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pry[i]) g_idle = IW'(i);
    end
  end

  // While locked only the owner is visible to the mux, so g_vld is its valid.
  assign sel = (state == IDLE) ? pry : (lock_oh & req_vld);
  assign g   = (state == IDLE) ? g_idle : lock_idx;

  mux_pry #(
    .DAT_T          (DAT_T),
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_mux (
    .sel (sel),
    .dat (req_dat),
    .vld (g_vld),
    .out (g_dat)
  );

  // Handshake: a beat moves when valid and ready are both high on a rising
  // edge; ready is offered only to the granted requester while the stage can load.
  assign ld   = !out_vld || out_rdy;
  assign xfer = ld && g_vld;

  always_comb begin
    req_rdy = '0;
    if (xfer) req_rdy[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_lst <= 1'b0;
      out_idx <= '0;
      out_dat <= '0;
    end else if (xfer) begin
      out_vld <= 1'b1;
      out_lst <= req_lst[g];
      out_idx <= g;
      out_dat <= g_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_idx <= '0;
      ptr      <= '0;
    end else if (xfer) begin
      if (req_lst[g]) begin
        state <= IDLE;
        ptr   <= (g == IW'(WIDTH - 1)) ? '0 : g + IW'(1);
      end else begin
        state    <= LOCK;
        lock_idx <= g;
      end
    end
  end

`ifdef ARB_RR_PRY_CNT_EN
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt[i] <= '0;
        end else if (req_vld[i] && req_rdy[i] && (cnt[i] != 16'hFFFF)) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_arb_rr_pry.sv
// Bench for arb_rr_pry: directed scenarios plus random traffic against a
// behavioural round-robin/lock model and an output-beat scoreboard.

module tb_arb_rr_pry;

  localparam int W  = 5;
  localparam int IW = $clog2(W);
  localparam int BW = 1 + IW + 8;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    req_vld;
  logic [W-1:0]    req_lst;
  logic [7:0]      req_dat [W-1:0];
  logic [W-1:0]    req_rdy;
  logic            out_vld;
  logic            out_lst;
  logic [IW-1:0]   out_idx;
  logic [7:0]      out_dat;
  logic            out_rdy;
`ifdef ARB_RR_PRY_CNT_EN
  logic [15:0]     cnt [W-1:0];
`endif

  arb_rr_pry #(
    .DAT_T          (logic [7:0]),
    .WIDTH          (W),
    .SPLIT          (2),
    .IMPLEMENTATION (0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_lst (req_lst),
    .req_dat (req_dat),
    .req_rdy (req_rdy),
    .out_vld (out_vld),
    .out_lst (out_lst),
    .out_idx (out_idx),
    .out_dat (out_dat),
    .out_rdy (out_rdy)
`ifdef ARB_RR_PRY_CNT_EN
    ,
    .cnt     (cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int            n_vec;
  int            n_err;
  int            m_ptr;
  bit            m_lock;
  int            m_lidx;
  int            m_cnt [W];
  int            last_win;
  logic [7:0]    nxt_dat [W-1:0];
  logic [BW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = 0;
    m_lidx = 0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  // Winner = owner while locked, else first valid requester scanning circularly from ptr.
  function automatic int model_winner();
    if (m_lock) return req_vld[m_lidx] ? m_lidx : -1;
    for (int k = 0; k < W; k++) begin
      int i;
      i = (m_ptr + k) % W;
      if (req_vld[i]) return i;
    end
    return -1;
  endfunction

  // driver + checker + model update for one clock cycle
  task automatic step(input logic [W-1:0] v, input logic [W-1:0] l, input logic ordy);
    int         win;
    logic [W-1:0] er;
    @(negedge clk);
    req_vld = v;
    req_lst = l;
    out_rdy = ordy;
    for (int i = 0; i < W; i++) req_dat[i] = nxt_dat[i];
    #1;
    win = model_winner();
    er  = '0;
    if (win >= 0 && (exp_q.size() == 0 || ordy)) er[win] = 1'b1;
    chk("req_rdy", 32'(req_rdy), 32'(er));
    chk("out_vld", 32'(out_vld), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_beat", 32'({out_lst, out_idx, out_dat}), 32'(exp_q[0]));
`ifdef ARB_RR_PRY_CNT_EN
    for (int i = 0; i < W; i++) chk("cnt", 32'(cnt[i]), 32'(m_cnt[i]));
`endif
    @(posedge clk);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    last_win = -1;
    if (er != '0) begin
      last_win = win;
      exp_q.push_back({l[win], IW'(win), req_dat[win]});
      if (m_cnt[win] < 16'hFFFF) m_cnt[win]++;
      if (l[win]) begin
        m_lock = 0;
        m_ptr  = (win + 1) % W;
      end else begin
        m_lock = 1;
        m_lidx = win;
      end
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_vld = '0;
    req_lst = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_dat", 32'(out_dat), 32'd0);
    chk("rst_out_lst", 32'(out_lst), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_dat();
    for (int i = 0; i < W; i++) nxt_dat[i] = 8'($urandom);
  endtask

  initial begin
    int           seq [5];
    logic [W-1:0] hv;
    logic [W-1:0] hl;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < W; i++) begin
      req_dat[i] = '0;
      nxt_dat[i] = '0;
    end

    // round robin over 10101, single-beat packets
    do_reset();
    seq = '{0, 2, 4, 0, 2};
    for (int k = 0; k < 5; k++) begin
      rand_dat();
      step(5'b10101, 5'b11111, 1'b1);
      chk("rr_seq", 32'(last_win), 32'(seq[k]));
      if (k == 0) chk("first_vld_lat", 32'(out_vld), 32'd0);
      if (k == 1) chk("second_vld", 32'(out_vld), 32'd1);
    end
    step(5'b00000, 5'b00000, 1'b1);
    step(5'b00000, 5'b00000, 1'b1);

    // 3-beat packet on 1 locks out 3; ptr then lands on 4
    do_reset();
    seq = '{1, 1, 1, 3, 4};
    rand_dat();
    step(5'b01010, 5'b01000, 1'b1);
    chk("pkt_win", 32'(last_win), 32'(seq[0]));
    rand_dat();
    step(5'b01010, 5'b01000, 1'b1);
    chk("pkt_win", 32'(last_win), 32'(seq[1]));
    rand_dat();
    step(5'b01010, 5'b01010, 1'b1);
    chk("pkt_win", 32'(last_win), 32'(seq[2]));
    rand_dat();
    step(5'b01000, 5'b01000, 1'b1);
    chk("pkt_win", 32'(last_win), 32'(seq[3]));
    rand_dat();
    step(5'b11111, 5'b11111, 1'b1);
    chk("pkt_ptr4", 32'(last_win), 32'(seq[4]));
    step(5'b00000, 5'b00000, 1'b1);

    // lock gap: owner 2 drops valid, requester 0 must wait
    do_reset();
    rand_dat();
    step(5'b00100, 5'b00000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(5'b00001, 5'b00001, 1'b1);
      chk("gap_no_grant", 32'(last_win), 32'hFFFF_FFFF);
    end
    rand_dat();
    step(5'b00101, 5'b00101, 1'b1);
    chk("gap_resume", 32'(last_win), 32'd2);
    step(5'b00001, 5'b00001, 1'b1);
    chk("gap_after", 32'(last_win), 32'd0);
    step(5'b00000, 5'b00000, 1'b1);

    // backpressure with A5 held in the stage
    do_reset();
    nxt_dat[0] = 8'hA5;
    step(5'b00001, 5'b00001, 1'b1);
    nxt_dat[0] = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      step(5'b00001, 5'b00001, 1'b0);
      chk("bp_stall", 32'(last_win), 32'hFFFF_FFFF);
      chk("bp_dat", 32'(out_dat), 32'hA5);
    end
    step(5'b00001, 5'b00001, 1'b1);
    chk("bp_resume", 32'(last_win), 32'd0);
    step(5'b00000, 5'b00000, 1'b1);
    chk("bp_next_dat", 32'(out_dat), 32'h5A);

    // wrap: drive ptr to 4, then 00011 yields 0 then 1
    do_reset();
    rand_dat();
    step(5'b01000, 5'b01000, 1'b1);
    rand_dat();
    step(5'b00011, 5'b00011, 1'b1);
    chk("wrap_g0", 32'(last_win), 32'd0);
    rand_dat();
    step(5'b00011, 5'b00011, 1'b1);
    chk("wrap_g1", 32'(last_win), 32'd1);
    step(5'b00000, 5'b00000, 1'b1);

    // async reset while locked with a beat in the stage
    do_reset();
    rand_dat();
    step(5'b00100, 5'b00000, 1'b0);
    step(5'b00100, 5'b00000, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_vld", 32'(out_vld), 32'd0);
    chk("areset_idx", 32'(out_idx), 32'd0);
`ifdef ARB_RR_PRY_CNT_EN
    for (int i = 0; i < W; i++) chk("areset_cnt", 32'(cnt[i]), 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_dat();
    step(5'b11111, 5'b11111, 1'b1);
    chk("areset_restart", 32'(last_win), 32'd0);
    step(5'b00000, 5'b00000, 1'b1);

    // random traffic: requesters hold a beat until accepted, sometimes withdraw
    do_reset();
    hv = '0;
    hl = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++) begin
        if (!hv[i]) begin
          if ($urandom_range(0, 9) < 5) begin
            hv[i]      = 1'b1;
            hl[i]      = ($urandom_range(0, 2) == 0);
            nxt_dat[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          hv[i] = 1'b0;
        end
      end
      step(hv, hl, $urandom_range(0, 3) != 0);
      if (last_win >= 0) hv[last_win] = 1'b0;
    end
    for (int k = 0; k < 3; k++) step(5'b00000, 5'b00000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
